// File: rtl/debug_trace_module.sv
// Memory-mapped debug peripheral: NUM_CH debug channel registers plus a DEPTH-entry trace FIFO.
// Optional per-entry timestamps are enabled by defining DEBUG_TIMESTAMP_EN.
module debug_trace_module #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  debug_out,
  output logic        trace_nempty,
  output logic        trace_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [5:0] W_PUSH = 6'h10;
  localparam logic [5:0] W_POP  = 6'h11;
  localparam logic [5:0] W_STAT = 6'h12;
  localparam logic [5:0] W_CTRL = 6'h13;
  localparam logic [5:0] W_TS   = 6'h14;

  logic [5:0]            word;
  logic [DATA_WIDTH-1:0] ch  [NUM_CH];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow, underflow;
  logic [2:0]            sel;
  logic                  wr_en, rd_en, is_full, is_empty;
  logic                  push_req, pop_req, ctrl_wr, do_push, do_pop;
  logic                  fifo_clr, flag_clr;
  logic [31:0]           ts_rd;
  logic                  unused_bits;

  function automatic logic [31:0] zext(input logic [DATA_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[DATA_WIDTH-1:0] = v;
    return r;
  endfunction

  assign word        = address[7:2];
  assign unused_bits = ^{address[1:0], write_data};

  // A simultaneous write wins the bus cycle; the read strobe is dropped.
  assign wr_en    = we;
  assign rd_en    = re & ~we;
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);
  assign push_req = wr_en && (word == W_PUSH);
  assign pop_req  = rd_en && (word == W_POP);
  assign ctrl_wr  = wr_en && (word == W_CTRL);
  assign do_push  = push_req && !is_full;
  assign do_pop   = pop_req && !is_empty;
  assign fifo_clr = ctrl_wr && write_data[0];
  assign flag_clr = ctrl_wr && write_data[1];

  assign trace_nempty = !is_empty;
  assign trace_full   = is_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_CH; n++) ch[n] <= '0;
      sel <= '0;
    end else if (wr_en) begin
      for (int unsigned n = 0; n < NUM_CH; n++)
        if (word == 6'(n)) ch[n] <= write_data[DATA_WIDTH-1:0];
      if (ctrl_wr) sel <= write_data[6:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + CW'(1);
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flag_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_req && is_full)  overflow  <= 1'b1;
      if (pop_req && is_empty) underflow <= 1'b1;
    end
  end

  // Storage is not reset: emptiness is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_data[DATA_WIDTH-1:0];
  end

`ifdef DEBUG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt, ts_latched;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt     <= '0;
      ts_latched <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (do_pop) ts_latched <= ts_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ts_mem[wr_ptr] <= ts_cnt;
  end

  always_comb begin
    ts_rd = '0;
    ts_rd[TS_WIDTH-1:0] = ts_latched;
  end
`else
  assign ts_rd = '0;
`endif

  always_comb begin
    read_data = '0;
    if (word < 6'h10) begin
      for (int unsigned n = 0; n < NUM_CH; n++)
        if (word == 6'(n)) read_data = zext(ch[n]);
    end else begin
      case (word)
        W_POP:  if (!is_empty) read_data = zext(mem[rd_ptr]);
        W_STAT: begin
          read_data[0]        = is_empty;
          read_data[1]        = is_full;
          read_data[2]        = overflow;
          read_data[3]        = underflow;
          read_data[8 +: CW]  = count;
        end
        W_CTRL: read_data[6:4] = sel;
        W_TS:   read_data = ts_rd;
        default: read_data = '0;
      endcase
    end
  end

  always_comb begin
    logic [31:0] sel_word;
    sel_word = '0;
    for (int unsigned n = 0; n < NUM_CH; n++)
      if (sel == 3'(n)) sel_word = zext(ch[n]);
    debug_out = sel_word[7:0];
  end

endmodule

// File: tb/tb_debug_trace_module.sv
// Self-checking bench for debug_trace_module: queue-based reference model, per-cycle output
// compare, directed scenarios with literal expectations, then randomized bus traffic.
module tb_debug_trace_module;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;
  logic        we, re;
  logic [7:0]  debug_out;
  logic        trace_nempty, trace_full;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0]  m_ch [NCH];
  int unsigned  m_q[$];
  int unsigned  m_tsq[$];
  bit           m_ovf, m_unf;
  int unsigned  m_sel;
  int unsigned  m_ts_last;
  int unsigned  cyc;

  always #5 clk = ~clk;

  debug_trace_module #(
    .DATA_WIDTH(DW),
    .NUM_CH(NCH),
    .DEPTH(DEP),
    .TS_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .we(we),
    .re(re),
    .debug_out(debug_out),
    .trace_nempty(trace_nempty),
    .trace_full(trace_full)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dmask();
    return (DW >= 32) ? 32'hFFFF_FFFF : ((32'h1 << DW) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_ch[i] = '0;
    m_q.delete();
    m_tsq.delete();
    m_ovf = 0; m_unf = 0; m_sel = 0; m_ts_last = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int unsigned w = a[7:2];
    int unsigned sz = m_q.size();
    if (w < 16) return (w < NCH) ? m_ch[w] : 32'h0;
    case (w)
      17: return (sz == 0) ? 32'h0 : m_q[0];
      18: return (sz << 8) | (m_unf << 3) | (m_ovf << 2) |
                 ((sz == DEP) ? 32'h2 : 32'h0) | ((sz == 0) ? 32'h1 : 32'h0);
      19: return m_sel << 4;
`ifdef DEBUG_TIMESTAMP_EN
      20: return m_ts_last;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] model_dbg();
    logic [31:0] v;
    v = (m_sel < NCH) ? m_ch[m_sel] : 32'h0;
    return v[7:0];
  endfunction

  // Applied just after the access edge; cyc has already advanced past the push edge.
  task automatic model_apply(input logic [7:0] a, input logic [31:0] d, input logic w, input logic r);
    int unsigned wd = a[7:2];
    if (w) begin
      if (wd < NCH) m_ch[wd] = d & dmask();
      else if (wd == 16) begin
        if (m_q.size() == DEP) m_ovf = 1;
        else begin
          m_q.push_back(d & dmask());
          m_tsq.push_back(cyc - 1);
        end
      end else if (wd == 19) begin
        m_sel = d[6:4];
        if (d[0]) begin m_q.delete(); m_tsq.delete(); end
        if (d[1]) begin m_ovf = 0; m_unf = 0; end
      end
    end else if (r && wd == 17) begin
      if (m_q.size() == 0) m_unf = 1;
      else begin
        void'(m_q.pop_front());
        m_ts_last = m_tsq.pop_front();
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("debug_out", {24'h0, debug_out}, {24'h0, model_dbg()});
      check("trace_nempty", {31'h0, trace_nempty}, {31'h0, m_q.size() != 0});
      check("trace_full", {31'h0, trace_full}, {31'h0, m_q.size() == DEP});
    end
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic w, input logic r,
                     output logic [31:0] rv);
    @(negedge clk);
    address = a; write_data = d; we = w; re = r;
    #1;
    rv = read_data;
    check("read_data", rv, model_read(a));
    @(posedge clk);
    #1;
    model_apply(a, d, w, r);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 1'b1, 1'b0, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus(a, 32'h0, 1'b0, 1'b1, v);
  endtask

  task automatic pop(output logic [31:0] v);
    rd(8'h44, v);
  endtask

  task automatic reset_mid_push(input logic [31:0] d);
    @(negedge clk);
    address = 8'h40; write_data = d; we = 1'b1; re = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    we = 1'b0;
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int unsigned tcap;
    int unsigned r;
    address = '0; write_data = '0; we = 1'b0; re = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    rd(8'h48, v);           check("t1_status", v, 32'h1);
    check("t1_dbg", {24'h0, debug_out}, 32'h0);
    check("t1_nempty", {31'h0, trace_nempty}, 32'h0);

    wr(8'h08, 32'hA5A5_1234);
    wr(8'h4C, 32'h20);      check("t2_dbg", {24'h0, debug_out}, 32'h34);
    rd(8'h08, v);           check("t2_ch2", v, 32'hA5A5_1234);
    wr(8'h4C, 32'h70);      check("t2_dbg_oob", {24'h0, debug_out}, 32'h0);

    wr(8'h40, 32'h11); wr(8'h40, 32'h22); wr(8'h40, 32'h33);
    pop(v); check("t3_pop0", v, 32'h11);
    pop(v); check("t3_pop1", v, 32'h22);
    pop(v); check("t3_pop2", v, 32'h33);
    rd(8'h48, v); check("t3_status", v, 32'h1);

    for (int i = 0; i < 16; i++) wr(8'h40, i);
    check("t4_full", {31'h0, trace_full}, 32'h1);
    rd(8'h48, v); check("t4_status_full", v, 32'h0000_1002);
    wr(8'h40, 32'h99);
    rd(8'h48, v); check("t4_status_ovf", v, 32'h0000_1006);
    for (int i = 0; i < 16; i++) begin
      pop(v); check("t4_pop", v, i);
    end
    pop(v); check("t4_pop_empty", v, 32'h0);
    rd(8'h48, v); check("t4_status_unf", v, 32'h0000_000D);
    wr(8'h4C, 32'h2);
    rd(8'h48, v); check("t4_status_clr", v, 32'h1);

    for (int i = 0; i < 4; i++) wr(8'h40, 32'hC0 + i);
    wr(8'h4C, 32'h1);
    check("t5_nempty", {31'h0, trace_nempty}, 32'h0);
    rd(8'h48, v); check("t5_status", v, 32'h1);
    wr(8'h40, 32'h7);
    pop(v); check("t5_pop", v, 32'h7);

    wr(8'h00, 32'hDEAD_BEEF);
    wr(8'h40, 32'h1); wr(8'h40, 32'h2);
    reset_mid_push(32'h55);
    rd(8'h48, v); check("t6_status", v, 32'h1);
    for (int i = 0; i < NCH; i++) begin
      rd(8'(4 * i), v); check("t6_ch", v, 32'h0);
    end

`ifdef DEBUG_TIMESTAMP_EN
    repeat (3) @(posedge clk);
    #1 tcap = cyc;
    wr(8'h40, 32'hAB);
    pop(v);
    rd(8'h50, v); check("t6_timestamp", v, tcap);
`endif

    for (int it = 0; it < 800; it++) begin
      r = $urandom_range(0, 99);
      if (r < 22)      wr(8'h40, $urandom);
      else if (r < 42) pop(v);
      else if (r < 54) wr(8'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom);
      else if (r < 70) rd(8'($urandom), v);
      else if (r < 78) wr(8'h4C, ($urandom & 32'h72) | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0));
      else if (r < 86) bus(($urandom_range(0, 1) != 0) ? 8'h44 : 8'h40, $urandom, 1'b1, 1'b1, v);
      else if (r < 98) wr(8'($urandom), $urandom);
      else             reset_mid_push($urandom);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
